// File: rtl/parking_lot_pkg.sv
// Shared types and defaults for the parking-lot controller slice.
package parking_lot_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StOpen = 1'b1
  } entry_state_e;

  localparam int unsigned DefaultNumSlots    = 8;
  localparam int unsigned DefaultGateTimeout = 100;
  localparam int unsigned StatsW             = 16;

  function automatic logic [StatsW-1:0] sat_inc(input logic [StatsW-1:0] val);
    return (val == '1) ? val : val + StatsW'(1);
  endfunction

endpackage

// File: rtl/parking_slot_finder.sv
// Combinational priority encoder: lowest-index free slot plus an any-free flag.
module parking_slot_finder #(
  parameter int unsigned NUM_SLOTS = 8,
  parameter int unsigned SLOT_W    = 3
) (
  input  logic [NUM_SLOTS-1:0] occupancy_i,
  output logic [SLOT_W-1:0]    free_idx_o,
  output logic                 any_free_o
);

  // Scan high to low so the lowest free index is the last one written.
  always_comb begin
    free_idx_o = '0;
    any_free_o = 1'b0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!occupancy_i[i]) begin
        free_idx_o = SLOT_W'(i);
        any_free_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_lot_controller.sv
// Slot occupancy tracker with entry-gate FSM (timeout) and exit release path.
// Optional statistics counters are enabled with PARKING_LOT_STATS_EN.
module parking_lot_controller
  import parking_lot_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = DefaultNumSlots,
  parameter int unsigned SLOT_W       = 3,
  parameter int unsigned GATE_TIMEOUT = DefaultGateTimeout
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enter_req,
  input  logic                 car_passed,
  input  logic                 exit_valid,
  input  logic [SLOT_W-1:0]    exit_slot,
  output logic                 gate_open,
  output logic [SLOT_W-1:0]    enter_slot,
  output logic                 enter_reject,
  output logic                 gate_timeout,
  output logic                 exit_error,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W:0]      free_count,
  output logic                 full,
  output logic                 empty
`ifdef PARKING_LOT_STATS_EN
  ,
  output logic [StatsW-1:0]    total_entries,
  output logic [StatsW-1:0]    total_rejects
`endif
);

  localparam int unsigned TimerW = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(GATE_TIMEOUT - 1);

  entry_state_e state_q, state_d;

  logic [TimerW-1:0]    timer_q, timer_d;
  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic                 gate_open_q, gate_open_d;
  logic [SLOT_W-1:0]    enter_slot_q, enter_slot_d;
  logic                 reject_q, reject_d;
  logic                 timeout_q, timeout_d;
  logic                 exit_err_q, exit_err_d;
  logic [SLOT_W:0]      free_count_q, free_count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;

  logic [SLOT_W-1:0]    free_idx;
  logic                 any_free;
  logic                 alloc;
  logic                 release_slot;
  logic [NUM_SLOTS-1:0] alloc_dec, slot_dec, exit_dec;
  logic                 exit_in_range, exit_ok;
  logic [SLOT_W:0]      used_cnt;

  parking_slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .SLOT_W    (SLOT_W)
  ) u_finder (
    .occupancy_i (occ_q),
    .free_idx_o  (free_idx),
    .any_free_o  (any_free)
  );

  // Entry FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Entry FSM: next state. car_passed has priority over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (enter_req && any_free) state_d = StOpen;
      StOpen: if (car_passed || (timer_q == TimerLast)) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Entry FSM: outputs and datapath controls.
  always_comb begin
    timer_d      = timer_q;
    gate_open_d  = gate_open_q;
    enter_slot_d = enter_slot_q;
    reject_d     = 1'b0;
    timeout_d    = 1'b0;
    alloc        = 1'b0;
    release_slot = 1'b0;
    unique case (state_q)
      StIdle: begin
        timer_d = '0;
        if (enter_req) begin
          if (any_free) begin
            alloc        = 1'b1;
            enter_slot_d = free_idx;
            gate_open_d  = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StOpen: begin
        if (car_passed) begin
          gate_open_d = 1'b0;
        end else if (timer_q == TimerLast) begin
          gate_open_d  = 1'b0;
          timeout_d    = 1'b1;
          release_slot = 1'b1;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      default: ;
    endcase
  end

  // Occupancy update: allocation uses pre-exit occupancy, so a slot vacated
  // this cycle is never handed out in the same cycle.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      alloc_dec[i] = (free_idx == SLOT_W'(i));
      slot_dec[i]  = (enter_slot_q == SLOT_W'(i));
      exit_dec[i]  = (exit_slot == SLOT_W'(i));
    end
    exit_in_range = (32'(exit_slot) < NUM_SLOTS);
    exit_ok       = exit_valid && exit_in_range && |(exit_dec & occ_q);
    exit_err_d    = exit_valid && !exit_ok;

    occ_d = occ_q;
    if (alloc)        occ_d = occ_d | alloc_dec;
    if (release_slot) occ_d = occ_d & ~slot_dec;
    if (exit_ok)      occ_d = occ_d & ~exit_dec;

    used_cnt = '0;
    for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
      used_cnt = used_cnt + (SLOT_W+1)'(occ_d[i]);
    end
    free_count_d = (SLOT_W+1)'(NUM_SLOTS) - used_cnt;
    full_d       = &occ_d;
    empty_d      = ~|occ_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q      <= '0;
      occ_q        <= '0;
      gate_open_q  <= 1'b0;
      enter_slot_q <= '0;
      reject_q     <= 1'b0;
      timeout_q    <= 1'b0;
      exit_err_q   <= 1'b0;
      free_count_q <= (SLOT_W+1)'(NUM_SLOTS);
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
    end else begin
      timer_q      <= timer_d;
      occ_q        <= occ_d;
      gate_open_q  <= gate_open_d;
      enter_slot_q <= enter_slot_d;
      reject_q     <= reject_d;
      timeout_q    <= timeout_d;
      exit_err_q   <= exit_err_d;
      free_count_q <= free_count_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
    end
  end

  assign gate_open    = gate_open_q;
  assign enter_slot   = enter_slot_q;
  assign enter_reject = reject_q;
  assign gate_timeout = timeout_q;
  assign exit_error   = exit_err_q;
  assign occupancy    = occ_q;
  assign free_count   = free_count_q;
  assign full         = full_q;
  assign empty        = empty_q;

`ifdef PARKING_LOT_STATS_EN
  logic [StatsW-1:0] entries_q, entries_d;
  logic [StatsW-1:0] rejects_q, rejects_d;

  always_comb begin
    entries_d = ((state_q == StOpen) && car_passed) ? sat_inc(entries_q) : entries_q;
    rejects_d = reject_d ? sat_inc(rejects_q) : rejects_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries_q <= '0;
      rejects_q <= '0;
    end else begin
      entries_q <= entries_d;
      rejects_q <= rejects_d;
    end
  end

  assign total_entries = entries_q;
  assign total_rejects = rejects_q;
`endif

endmodule

// File: tb/tb_parking_lot_controller.sv
// Self-checking bench for parking_lot_controller: directed scenarios plus random
// traffic compared against a behavioural slot-list model.
module tb_parking_lot_controller;
  import parking_lot_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned SW = 3;
  localparam int unsigned TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enter_req, car_passed, exit_valid;
  logic [SW-1:0] exit_slot;
  logic          gate_open, enter_reject, gate_timeout, exit_error, full, empty;
  logic [SW-1:0] enter_slot;
  logic [N-1:0]  occupancy;
  logic [SW:0]   free_count;
`ifdef PARKING_LOT_STATS_EN
  logic [StatsW-1:0] total_entries, total_rejects;
`endif

  always #5 clk = ~clk;

  parking_lot_controller #(
    .NUM_SLOTS    (N),
    .SLOT_W       (SW),
    .GATE_TIMEOUT (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enter_req    (enter_req),
    .car_passed   (car_passed),
    .exit_valid   (exit_valid),
    .exit_slot    (exit_slot),
    .gate_open    (gate_open),
    .enter_slot   (enter_slot),
    .enter_reject (enter_reject),
    .gate_timeout (gate_timeout),
    .exit_error   (exit_error),
    .occupancy    (occupancy),
    .free_count   (free_count),
    .full         (full),
    .empty        (empty)
`ifdef PARKING_LOT_STATS_EN
    ,
    .total_entries (total_entries),
    .total_rejects (total_rejects)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: a list of taken slots plus a gate record.
  bit taken[N];
  bit m_open;
  int m_timer, m_slot;
  bit m_rej, m_to, m_err;
  int m_entries, m_rejects;

  function automatic int n_free();
    int c = 0;
    for (int i = 0; i < int'(N); i++) if (!taken[i]) c++;
    return c;
  endfunction

  function automatic logic [N-1:0] occ_vec();
    logic [N-1:0] v;
    for (int i = 0; i < int'(N); i++) v[i] = taken[i];
    return v;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(N); i++) taken[i] = 1'b0;
    m_open = 0; m_timer = 0; m_slot = 0;
    m_rej = 0; m_to = 0; m_err = 0;
    m_entries = 0; m_rejects = 0;
  endtask

  task automatic m_step(input bit req, input bit pass, input bit ev, input int es);
    bit nxt[N];
    nxt = taken;
    m_rej = 0; m_to = 0; m_err = 0;
    if (!m_open) begin
      if (req) begin
        if (n_free() == 0) begin
          m_rej = 1;
          if (m_rejects < 65535) m_rejects++;
        end else begin
          int k = 0;
          while (taken[k]) k++;
          nxt[k] = 1; m_slot = k; m_open = 1; m_timer = 0;
        end
      end
    end else if (pass) begin
      m_open = 0;
      if (m_entries < 65535) m_entries++;
    end else if (m_timer == int'(TO) - 1) begin
      nxt[m_slot] = 0; m_open = 0; m_to = 1;
    end else begin
      m_timer++;
    end
    if (ev) begin
      if (es < int'(N) && taken[es]) nxt[es] = 0;
      else m_err = 1;
    end
    taken = nxt;
  endtask

  task automatic check_all();
    check("occupancy", 32'(occupancy), 32'(occ_vec()));
    check("free_count", 32'(free_count), 32'(n_free()));
    check("full", 32'(full), 32'(n_free() == 0));
    check("empty", 32'(empty), 32'(n_free() == int'(N)));
    check("gate_open", 32'(gate_open), 32'(m_open));
    check("enter_slot", 32'(enter_slot), 32'(m_slot));
    check("enter_reject", 32'(enter_reject), 32'(m_rej));
    check("gate_timeout", 32'(gate_timeout), 32'(m_to));
    check("exit_error", 32'(exit_error), 32'(m_err));
`ifdef PARKING_LOT_STATS_EN
    check("total_entries", 32'(total_entries), 32'(m_entries));
    check("total_rejects", 32'(total_rejects), 32'(m_rejects));
`endif
  endtask

  // Called at a falling edge: drive, let one rising edge pass, check.
  task automatic cycle(input bit req, input bit pass, input bit ev, input int es);
    enter_req  = req;
    car_passed = pass;
    exit_valid = ev;
    exit_slot  = SW'(es);
    m_step(req, pass, ev, es);
    @(negedge clk);
    check_all();
  endtask

  task automatic enter_car();
    cycle(1, 0, 0, 0);
    cycle(0, 1, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    enter_req = 0; car_passed = 0; exit_valid = 0; exit_slot = '0;
    m_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    rst = 1'b1;
    enter_req = 0; car_passed = 0; exit_valid = 0; exit_slot = '0;
    do_reset();
    check("rst_free", 32'(free_count), 32'd8);
    check("rst_empty", 32'(empty), 32'd1);

    // First entry, car passes two cycles after the request.
    cycle(1, 0, 0, 0);
    check("t1_gate", 32'(gate_open), 32'd1);
    check("t1_slot", 32'(enter_slot), 32'd0);
    check("t1_occ", 32'(occupancy), 32'h01);
    check("t1_free", 32'(free_count), 32'd7);
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    check("t1_closed", 32'(gate_open), 32'd0);

    // Fill the lot, then a rejected ninth request.
    do_reset();
    repeat (8) enter_car();
    check("t2_occ", 32'(occupancy), 32'hFF);
    check("t2_full", 32'(full), 32'd1);
    check("t2_free", 32'(free_count), 32'd0);
    cycle(1, 0, 0, 0);
    check("t2_reject", 32'(enter_reject), 32'd1);
    check("t2_occ_hold", 32'(occupancy), 32'hFF);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    check("t2_reject_off", 32'(enter_reject), 32'd0);

    // Timeout releases the allocated slot.
    do_reset();
    repeat (4) enter_car();
    cycle(1, 0, 0, 0);
    check("t3_slot", 32'(enter_slot), 32'd4);
    check("t3_occ", 32'(occupancy), 32'h1F);
    repeat (3) cycle(0, 0, 0, 0);
    check("t3_still_open", 32'(gate_open), 32'd1);
    cycle(0, 0, 0, 0);
    check("t3_timeout", 32'(gate_timeout), 32'd1);
    check("t3_occ_back", 32'(occupancy), 32'h0F);
    check("t3_gate", 32'(gate_open), 32'd0);
    cycle(0, 0, 0, 0);

    // Valid exit, then exit of a free slot.
    do_reset();
    repeat (3) enter_car();
    cycle(0, 0, 1, 1);
    check("t4_occ", 32'(occupancy), 32'h05);
    check("t4_free", 32'(free_count), 32'd6);
    cycle(0, 0, 1, 3);
    check("t4_err", 32'(exit_error), 32'd1);
    check("t4_occ_hold", 32'(occupancy), 32'h05);

    // Allocation and exit in the same cycle.
    do_reset();
    repeat (2) enter_car();
    cycle(1, 0, 1, 0);
    check("t5_slot", 32'(enter_slot), 32'd2);
    check("t5_occ", 32'(occupancy), 32'h06);
    check("t5_free", 32'(free_count), 32'd6);

    // Exit of the slot being entered, later timeout, stray car_passed.
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    check("t6_occ", 32'(occupancy), 32'h00);
    repeat (4) cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);

    // Asynchronous reset while the gate is open.
    do_reset();
    repeat (5) enter_car();
    cycle(1, 0, 0, 0);
    check("t7_occ", 32'(occupancy), 32'h3F);
    #1 rst = 1'b1;
    m_reset();
    #1;
    check_all();
    check("t7_gate", 32'(gate_open), 32'd0);
    check("t7_free", 32'(free_count), 32'd8);
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0), int'($urandom_range(0, N - 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/parking_lot_controller.md
Name: parking_lot_controller

Overview:
- Parametrised successor to the fixed 3-bit exit decoder. It tracks occupancy of NUM_SLOTS parking slots.
- Entry side: allocates the lowest free slot and runs an entry-gate FSM with a timeout.
- Exit side: releases slots by number.
- Sits between the entry/exit sensors and the display/status logic of the parking-lot design.

Parameters:
- NUM_SLOTS, 8: number of parking slots, 2..64.
- SLOT_W, 3: slot index width; must equal clog2(NUM_SLOTS).
- GATE_TIMEOUT, 100: cycles the gate stays open waiting for car_passed; must be at least 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- enter_req  in  1  car waiting at entry; level, sampled each cycle.
- car_passed  in  1  entry gate sensor; 1-cycle pulse when the car clears the gate.
- exit_valid  in  1  1-cycle pulse; a car is leaving slot exit_slot.
- exit_slot  in  SLOT_W  number of the slot being vacated.
- gate_open  out  1  entry gate command.
- enter_slot  out  SLOT_W  slot assigned to the current entering car; held while gate_open.
- enter_reject  out  1  1-cycle pulse; lot full when entry requested.
- gate_timeout  out  1  1-cycle pulse; allocation cancelled by timeout.
- exit_error  out  1  1-cycle pulse; exit of a free slot or an out-of-range slot.
- occupancy  out  NUM_SLOTS  bit i = 1 means slot i is taken.
- free_count  out  SLOT_W+1  number of free slots.
- full  out  1  all slots occupied.
- empty  out  1  no slots occupied.

Behaviour:
- Reset values (asynchronous, while rst=1):
  - occupancy=0, free_count=NUM_SLOTS, empty=1, full=0.
  - gate_open=0, enter_slot=0, all pulse outputs=0.
  - FSM in IDLE, timer=0.
- All outputs are registered. free_count, full and empty are derived from the next occupancy value, so they change in the same cycle as occupancy.
- Entry FSM, states IDLE and OPEN:
  - IDLE, enter_req=1, full=0: next cycle, set occupancy bit k (k = lowest-index free slot), enter_slot=k, gate_open=1, timer=0, go to OPEN. Latency from enter_req sampled to gate_open is 1 cycle.
  - IDLE, enter_req=1, full=1: enter_reject=1 for one cycle, stay IDLE. The pulse repeats every cycle while enter_req stays high and the lot stays full.
  - OPEN: enter_req is ignored; timer increments every cycle.
  - OPEN, car_passed=1: gate_open=0, go to IDLE; the slot stays occupied.
  - OPEN, timer reaches GATE_TIMEOUT-1 with car_passed=0: clear occupancy bit enter_slot, gate_open=0, gate_timeout=1 for one cycle, go to IDLE.
  - car_passed and timeout in the same cycle: car_passed wins; no release.
  - car_passed while IDLE: ignored.
- Exit path, independent of the FSM:
  - exit_valid=1 with exit_slot < NUM_SLOTS and that bit set: clear the bit next cycle.
  - Bit already clear, or exit_slot >= NUM_SLOTS: exit_error=1 for one cycle; occupancy unchanged.
- Simultaneous events:
  - Allocation in the same cycle as an exit: allocation sees the pre-exit occupancy, so the vacated slot is not reused that cycle. Both updates apply. free_count is net of both: unchanged if exit is valid, -1 if exit errors.
  - Exit of enter_slot while OPEN: valid clear. A later timeout then clears an already-clear bit silently, with no exit_error.
- Reset mid-operation: FSM returns to IDLE immediately; occupancy clears; the gate closes.

Optional Feature:
- Macro: PARKING_LOT_STATS_EN.
- Defined:
  - Extra output total_entries, 16 bits: increments on each car_passed accepted in OPEN; saturates at 16'hFFFF; reset 0.
  - Extra output total_rejects, 16 bits: increments on each enter_reject pulse; same saturation and reset.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package/header parking_lot_pkg:
  - entry FSM state encodings (ST_IDLE=0, ST_OPEN=1);
  - default NUM_SLOTS and GATE_TIMEOUT;
  - stats counter width (16).
- One sub-module, parking_slot_finder: combinational priority encoder, occupancy -> lowest free index plus any_free. Parametrised on NUM_SLOTS; replaces the hard-coded decoder approach.
- Exit bit-clear uses a parametrised one-hot decode inside the top module.

Test Plan (NUM_SLOTS=8, GATE_TIMEOUT=4):
- Reset, then enter_req=1 for one cycle, car_passed 2 cycles later -> gate_open=1 one cycle after req; enter_slot=0; occupancy=8'h01; free_count=7; gate_open=0 after car_passed.
- Eight successful entries -> occupancy=8'hFF, full=1, free_count=0. A ninth enter_req -> enter_reject pulse, occupancy unchanged.
- occupancy=8'h0F, enter_req, no car_passed -> enter_slot=4, occupancy=8'h1F. After 4 cycles in OPEN: gate_timeout pulse, occupancy=8'h0F, gate_open=0.
- occupancy=8'h07, exit_valid with exit_slot=1 -> occupancy=8'h05, free_count=6. exit_valid with exit_slot=3 -> exit_error pulse, occupancy stays 8'h05.
- occupancy=8'h03: same-cycle enter_req and exit_valid with exit_slot=0 -> enter_slot=2, occupancy=8'h06, free_count=6.
- Assert rst while OPEN with occupancy=8'h3F -> all outputs at reset values immediately, without waiting for a clock edge.
